// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception type codes and
// Status/Cause field positions used by the register file and pipeline control.
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK     = 32'h0000_0009;
    localparam logic [31:0] EXC_INST_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    localparam int unsigned STATUS_IE      = 0;
    localparam int unsigned STATUS_EXL     = 1;
    localparam int unsigned CAUSE_BD       = 31;
    localparam int unsigned CAUSE_IP_HW_HI = 15;
    localparam int unsigned CAUSE_IP_HW_LO = 10;
    localparam int unsigned CAUSE_IP_SW_HI = 9;
    localparam int unsigned CAUSE_IP_SW_LO = 8;
    localparam int unsigned CAUSE_EXC_HI   = 6;
    localparam int unsigned CAUSE_EXC_LO   = 2;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

    // Unrecognised nonzero codes are reported as an interrupt.
    function automatic logic [4:0] exc_code(input logic [31:0] excepttype);
        case (excepttype)
            EXC_SYSCALL:  exc_code = 5'd8;
            EXC_BREAK:    exc_code = 5'd9;
            EXC_INST_INV: exc_code = 5'd10;
            EXC_OVERFLOW: exc_code = 5'd12;
            EXC_TRAP:     exc_code = 5'd13;
            default:      exc_code = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId,
// Config, exception entry/eret bookkeeping and the mfc0 read mux.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    assign prid_o   = PRID_VALUE;
    assign config_o = CONFIG_VALUE;

    // NOTE: non-blocking assignments let the later exception overlay win per bit
    // over the mtc0 write issued earlier in the same block, while every
    // condition still reads the pre-edge register values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o     <= '0;
            compare_o   <= '0;
            status_o    <= STATUS_RESET;
            cause_o     <= '0;
            epc_o       <= '0;
            timer_int_o <= 1'b0;
        end else begin
            count_o <= count_o + 32'd1;
            cause_o[CAUSE_IP_HW_HI:CAUSE_IP_HW_LO] <= int_i;

            if (compare_o != 32'd0 && count_o == compare_o) begin
                timer_int_o <= 1'b1;
            end

            if (we_i) begin
                case (waddr_i)
                    CP0_REG_COUNT:   count_o <= data_i;
                    CP0_REG_COMPARE: begin
                        compare_o   <= data_i;
                        timer_int_o <= 1'b0;
                    end
                    CP0_REG_STATUS:  status_o <= data_i;
                    CP0_REG_CAUSE:   cause_o[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] <= data_i[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
                    CP0_REG_EPC:     epc_o <= data_i;
                    default: ;
                endcase
            end

            // Exception state is recorded only on the first, non-nested entry.
            if (excepttype_i == EXC_ERET) begin
                status_o[STATUS_EXL] <= 1'b0;
            end else if (excepttype_i != EXC_NONE) begin
                cause_o[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc_code(excepttype_i);
                status_o[STATUS_EXL] <= 1'b1;
                if (!status_o[STATUS_EXL]) begin
                    epc_o <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                               : current_inst_addr_i;
                    cause_o[CAUSE_BD] <= is_in_delayslot_i;
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = count_o;
            CP0_REG_COMPARE: data_o = compare_o;
            CP0_REG_STATUS:  data_o = status_o;
            CP0_REG_CAUSE:   data_o = cause_o;
            CP0_REG_EPC:     data_o = epc_o;
            CP0_REG_PRID:    data_o = prid_o;
            CP0_REG_CONFIG:  data_o = config_o;
            default:         data_o = '0;
        endcase
    end

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file for the five-stage MIPS pipeline. Holds Count, Compare, Status, Cause, EPC, PRId and Config, and generates the timer interrupt. It records exception state when the MEM stage reports an exception and exports EPC, the value the pipeline controller uses as the `eret` return target. It sits beside the MEM/WB boundary: mtc0 writes arrive from WB, and mfc0 reads are served to EX.

## Interface
- PRID_VALUE, 32'h00480102, read-only PRId contents
- CONFIG_VALUE, 32'h00008000, read-only Config contents (BE=1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- we_i  in  1  mtc0 write enable from WB
- waddr_i  in  5  mtc0 target register number
- data_i  in  32  mtc0 write data
- raddr_i  in  5  mfc0 source register number
- int_i  in  6  external hardware interrupt lines; top ties timer_int_o into int_i[5]
- excepttype_i  in  32  MEM-stage exception code; 0 = none
- current_inst_addr_i  in  32  PC of the MEM-stage instruction
- is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot
- data_o  out  32  mfc0 read data, combinational from raddr_i
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  live register values
- timer_int_o  out  1  timer interrupt request

## Operation
- **Register numbers:**
  - Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
  - Any other raddr_i reads 0. Writes to other numbers, PRId or Config are ignored.
- **Reset values:**
  - count 0, compare 0.
  - status 32'h10000000 (CU0=1, EXL=0, IE=0).
  - cause 0, epc 0, timer_int_o 0.
  - prid and config take their parameter values.
- **Count:**
  - Increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
  - An mtc0 to Count loads data_i, with no increment that cycle.
- **Timer interrupt:**
  - When compare != 0 and count == compare, timer_int_o is set on the next edge.
  - It stays set (sticky) until an mtc0 to Compare, which loads compare and clears timer_int_o in the same edge.
- **Cause:**
  - Cause[15:10] <= int_i every cycle.
  - Only Cause[9:8] (software IP) is writable by mtc0; all other Cause bits ignore writes.
- **Status:** fully writable by mtc0.
- **EPC:** fully writable by mtc0.
- **Exception entry** (excepttype_i ∉ {0, 32'h0e}):
  - ExcCode Cause[6:2] is set from the code: 0x01->0, 0x08->8, 0x09->9, 0x0a->10, 0x0c->12, 0x0d->13.
  - If Status.EXL == 0:
    - EPC <= current_inst_addr_i − 4 if is_in_delayslot_i, else current_inst_addr_i.
    - Cause.BD[31] <= is_in_delayslot_i.
  - If EXL == 1 already: EPC and BD are unchanged; only ExcCode updates.
  - Status.EXL[1] <= 1.
- **eret** (excepttype_i == 32'h0e): Status.EXL <= 0. No other field changes.
- **Unknown nonzero codes:** treated as an interrupt (ExcCode 0).
- **Simultaneous mtc0 and exception/eret in the same cycle:**
  - The mtc0 (older, in WB) is applied first.
  - Exception/eret field updates overlay it, so EXL, EPC, BD and ExcCode reflect the exception.
  - Other written fields keep the mtc0 value.

## Timing
- All writes and exception effects are visible on the *_o outputs one cycle after the edge that samples them.
- data_o is a combinational read of the current registered state, with no internal bypass; EX-stage forwarding handles the mtc0-to-mfc0 hazard.
- epc_o is stable in the cycle the `eret` reaches MEM, and the pipeline controller consumes it combinationally.
- Reset asserted mid-operation:
  - All registers return to their reset values at that edge, regardless of we_i or excepttype_i.
  - count resumes from 0 at the first edge with rst low, giving count_o = 1 one cycle after reset release.

## Structure
- Shared defines header holds:
  - CP0 register number constants (`CP0_REG_COUNT` … `CP0_REG_CONFIG`).
  - Exception type codes, shared with the pipeline controller.
  - Status/Cause bit-position constants (EXL, IE, BD, IP, ExcCode).
- No sub-module: one sequential process for register updates plus one combinational read mux.

## Test plan
- **Reset and count:** rst high 3 cycles, then low 5 cycles -> count_o = 5, status_o = 32'h10000000, all other outputs at reset values.
- **Timer:**
  - mtc0 Compare = 20 -> timer_int_o rises the cycle after count_o == 20 and holds.
  - mtc0 Compare = 100 -> timer_int_o = 0 on the next cycle.
- **Syscall not in delay slot:** excepttype_i = 8, PC = 32'h00400100, EXL = 0 -> epc_o = 32'h00400100, Cause[6:2] = 8, BD = 0, Status.EXL = 1.
- **Overflow in delay slot, then nested break:**
  - excepttype_i = 0x0c, PC = 32'h00400204, delayslot = 1 -> epc_o = 32'h00400200, BD = 1.
  - Then excepttype_i = 9 -> epc_o is unchanged and ExcCode = 9.
- **eret with a same-cycle write:** mtc0 Status = 32'h0000FF03 together with excepttype_i = 0x0e -> status_o = 32'h0000FF01.
- **Write filtering:**
  - mtc0 Cause = 32'hFFFFFFFF with int_i = 6'b000001 -> cause_o[15:8] = 8'b00000111, all other cause bits 0.
  - mtc0 to PRId -> prid_o unchanged.
